// File: rtl/i2c_color_target.sv
// ---------------------------------------------------------------------------
// i2c_color_target
// I2C target that emulates an RGB colour sensor so the colour read path can
// be closed in loopback without a physical sensor. SCL/SDA are oversampled on
// the system clock; the target serves a device ID, three R/W config registers
// and the red/green/blue 16-bit samples.
//
// Ports
//   clock      in   system clock (25 MHz)
//   reset      in   synchronous, active-high reset
//   scl_in     in   raw SCL pin level (asynchronous)
//   sda_in     in   raw SDA pin level (asynchronous)
//   sda_oe     out  1 = pull SDA low, 0 = release (open drain)
//   red        in   red sample   (0x0B low / 0x0C high)
//   green      in   green sample (0x09 low / 0x0A high)
//   blue       in   blue sample  (0x0D low / 0x0E high)
//   config1..3 out  config registers 0x01..0x03
//   wr_strobe  out  one-cycle pulse on any config register write
//   busy       out  high from START to STOP, addressed or not
// ---------------------------------------------------------------------------
module i2c_color_target #(
    parameter logic [6:0] DEVICE_ADDRESS = 7'h44,
    parameter logic [7:0] DEVICE_ID      = 8'h7D
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] red,
    input  logic [15:0] green,
    input  logic [15:0] blue,
    output logic [7:0]  config1,
    output logic [7:0]  config2,
    output logic [7:0]  config3,
    output logic        wr_strobe,
    output logic        busy
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_REG       = 4'd3,
        ST_REG_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } state_t;

    // Shadow layout: {red, green, blue}
    function automatic logic [7:0] reg_read(
        input logic [7:0]  ptr,
        input logic [47:0] shadow,
        input logic [7:0]  c1,
        input logic [7:0]  c2,
        input logic [7:0]  c3
    );
        logic [7:0] val;
        case (ptr)
            8'h00:   val = DEVICE_ID;
            8'h01:   val = c1;
            8'h02:   val = c2;
            8'h03:   val = c3;
            8'h09:   val = shadow[23:16];
            8'h0A:   val = shadow[31:24];
            8'h0B:   val = shadow[39:32];
            8'h0C:   val = shadow[47:40];
            8'h0D:   val = shadow[7:0];
            8'h0E:   val = shadow[15:8];
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    // Synchroniser stages [1:0] plus one stage of history for edge detection
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_hist_q;
    logic       sda_hist_q;

    logic       scl_s;
    logic       sda_s;
    logic       scl_rise_s;
    logic       scl_fall_s;
    logic       start_s;
    logic       stop_s;
    logic [7:0] rx_byte_s;
    logic [7:0] rd_byte_s;

    state_t      state_q;
    logic [3:0]  bit_cnt_q;
    logic [6:0]  shift_q;
    logic [7:0]  tx_q;
    logic [7:0]  ptr_q;
    logic        rw_q;
    logic        ack_phase_q;
    logic        sda_oe_q;
    logic        wr_strobe_q;
    logic        busy_q;
    logic [7:0]  config1_q;
    logic [7:0]  config2_q;
    logic [7:0]  config3_q;
    logic [47:0] shadow_q;

    // Two-flop synchronisers and edge history for the bus pins; idle bus is high
    always_ff @(posedge clock) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    assign scl_s      = scl_sync_q[1];
    assign sda_s      = sda_sync_q[1];
    assign scl_rise_s = scl_s & ~scl_hist_q;
    assign scl_fall_s = ~scl_s & scl_hist_q;
    // START/STOP are SDA transitions while SCL is stably high
    assign start_s    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_s     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    assign rx_byte_s  = {shift_q, sda_s};
    assign rd_byte_s  = reg_read(ptr_q, shadow_q, config1_q, config2_q, config3_q);

    // Protocol FSM: bus decode, register file access and the SDA driver
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 7'd0;
            tx_q        <= 8'h00;
            ptr_q       <= 8'h00;
            rw_q        <= 1'b0;
            ack_phase_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
            config1_q   <= 8'h00;
            config2_q   <= 8'h00;
            config3_q   <= 8'h00;
            shadow_q    <= 48'h0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (start_s) begin
                state_q     <= ST_ADDR;
                bit_cnt_q   <= 4'd0;
                ack_phase_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b1;
            end else if (stop_s) begin
                state_q     <= ST_IDLE;
                ack_phase_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        sda_oe_q <= 1'b0;
                    end

                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_q <= rx_byte_s[6:0];
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q   <= 4'd0;
                                ack_phase_q <= 1'b0;
                                if (rx_byte_s[7:1] == DEVICE_ADDRESS) begin
                                    rw_q    <= rx_byte_s[0];
                                    state_q <= ST_ADDR_ACK;
                                end else begin
                                    state_q <= ST_IGNORE;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end

                    // First falling edge drives ACK; second ends it and
                    // either starts the first read bit or waits for the pointer
                    ST_ADDR_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_phase_q) begin
                                sda_oe_q    <= 1'b1;
                                ack_phase_q <= 1'b1;
                                if (rw_q) begin
                                    shadow_q <= {red, green, blue};
                                end
                            end else begin
                                ack_phase_q <= 1'b0;
                                if (rw_q) begin
                                    tx_q      <= {rd_byte_s[6:0], 1'b0};
                                    sda_oe_q  <= ~rd_byte_s[7];
                                    bit_cnt_q <= 4'd1;
                                    state_q   <= ST_RDATA;
                                end else begin
                                    sda_oe_q  <= 1'b0;
                                    bit_cnt_q <= 4'd0;
                                    state_q   <= ST_REG;
                                end
                            end
                        end
                    end

                    ST_REG: begin
                        if (scl_rise_s) begin
                            shift_q <= rx_byte_s[6:0];
                            if (bit_cnt_q == 4'd7) begin
                                ptr_q       <= rx_byte_s;
                                bit_cnt_q   <= 4'd0;
                                ack_phase_q <= 1'b0;
                                state_q     <= ST_REG_ACK;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end

                    ST_REG_ACK, ST_WDATA_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_phase_q) begin
                                sda_oe_q    <= 1'b1;
                                ack_phase_q <= 1'b1;
                            end else begin
                                sda_oe_q    <= 1'b0;
                                ack_phase_q <= 1'b0;
                                bit_cnt_q   <= 4'd0;
                                state_q     <= ST_WDATA;
                            end
                        end
                    end

                    // Only 0x01..0x03 are writable; other bytes are ACKed and dropped
                    ST_WDATA: begin
                        if (scl_rise_s) begin
                            shift_q <= rx_byte_s[6:0];
                            if (bit_cnt_q == 4'd7) begin
                                case (ptr_q)
                                    8'h01: begin
                                        config1_q   <= rx_byte_s;
                                        wr_strobe_q <= 1'b1;
                                    end
                                    8'h02: begin
                                        config2_q   <= rx_byte_s;
                                        wr_strobe_q <= 1'b1;
                                    end
                                    8'h03: begin
                                        config3_q   <= rx_byte_s;
                                        wr_strobe_q <= 1'b1;
                                    end
                                    default: begin
                                        wr_strobe_q <= 1'b0;
                                    end
                                endcase
                                ptr_q       <= ptr_q + 8'd1;
                                bit_cnt_q   <= 4'd0;
                                ack_phase_q <= 1'b0;
                                state_q     <= ST_WDATA_ACK;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end

                    // bit_cnt_q counts bits already placed on the bus
                    ST_RDATA: begin
                        if (scl_fall_s) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q    <= 1'b0;
                                ack_phase_q <= 1'b0;
                                state_q     <= ST_RDATA_ACK;
                            end else begin
                                sda_oe_q  <= ~tx_q[7];
                                tx_q      <= {tx_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end

                    // Master ACK advances the pointer; NACK ends the read
                    ST_RDATA_ACK: begin
                        if (scl_rise_s) begin
                            if (!sda_s) begin
                                ptr_q       <= ptr_q + 8'd1;
                                ack_phase_q <= 1'b1;
                            end else begin
                                state_q <= ST_IGNORE;
                            end
                        end else if (scl_fall_s && ack_phase_q) begin
                            tx_q        <= {rd_byte_s[6:0], 1'b0};
                            sda_oe_q    <= ~rd_byte_s[7];
                            bit_cnt_q   <= 4'd1;
                            ack_phase_q <= 1'b0;
                            state_q     <= ST_RDATA;
                        end
                    end

                    ST_IGNORE: begin
                        sda_oe_q <= 1'b0;
                    end

                    default: begin
                        sda_oe_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign wr_strobe = wr_strobe_q;
    assign busy      = busy_q;
    assign config1   = config1_q;
    assign config2   = config2_q;
    assign config3   = config3_q;

endmodule

// File: tb/tb_i2c_color_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_color_target
// Bit-banged I2C master driving i2c_color_target through directed
// transactions; expected bytes and flags are written out by hand.
// ---------------------------------------------------------------------------
module tb_i2c_color_target;

    localparam int Q = 8; // quarter SCL period in system clocks

    logic        clock;
    logic        reset;
    logic        scl;
    logic        sda_m;
    logic        bus_sda;
    logic        sda_oe;
    logic [15:0] red;
    logic [15:0] green;
    logic [15:0] blue;
    logic [7:0]  config1;
    logic [7:0]  config2;
    logic [7:0]  config3;
    logic        wr_strobe;
    logic        busy;

    int n_cmp;
    int n_err;
    int strobe_cnt;

    // Wired-AND open-drain bus
    assign bus_sda = sda_m & ~sda_oe;

    i2c_color_target dut (
        .clock     (clock),
        .reset     (reset),
        .scl_in    (scl),
        .sda_in    (bus_sda),
        .sda_oe    (sda_oe),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .config1   (config1),
        .config2   (config2),
        .config3   (config3),
        .wr_strobe (wr_strobe),
        .busy      (busy)
    );

    // 25 MHz system clock
    initial begin
        clock = 1'b0;
        forever #20 clock = ~clock;
    end

    // Count write strobe pulses
    always @(posedge clock) begin
        if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl   = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic xfer_bit(input logic b, output logic seen);
        sda_m = b;    wait_q();
        scl   = 1'b1; wait_q();
        seen  = bus_sda; wait_q();
        scl   = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) xfer_bit(d[i], s);
        xfer_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, s);
            d[i] = s;
        end
        xfer_bit(~ack, s);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        n_cmp++; if (config1 !== 8'h00) begin n_err++; $display("FAIL reset_config1: got %h expected 00", config1); end
        n_cmp++; if (config2 !== 8'h00) begin n_err++; $display("FAIL reset_config2: got %h expected 00", config2); end
        n_cmp++; if (config3 !== 8'h00) begin n_err++; $display("FAIL reset_config3: got %h expected 00", config3); end
        n_cmp++; if (wr_strobe !== 1'b0) begin n_err++; $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_write_config();
        logic a0, a1, a2;
        int base;
        base = strobe_cnt;
        i2c_start();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_start: got %b expected 1", busy); end
        write_byte(8'h88, a0);
        write_byte(8'h01, a1);
        write_byte(8'h05, a2);
        i2c_stop();
        n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("FAIL wr_acks: got %b expected 111", {a0, a1, a2}); end
        n_cmp++; if (config1 !== 8'h05) begin n_err++; $display("FAIL wr_config1: got %h expected 05", config1); end
        n_cmp++; if (strobe_cnt - base !== 1) begin n_err++; $display("FAIL wr_strobe_count: got %0d expected 1", strobe_cnt - base); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_stop: got %b expected 0", busy); end
    endtask

    task automatic test_read_colour();
        logic a0, a1, a2;
        logic [7:0] b0, b1, b2, b3;
        red   = 16'h1234;
        green = 16'hABCD;
        i2c_start();
        write_byte(8'h88, a0);
        write_byte(8'h09, a1);
        i2c_start();
        write_byte(8'h89, a2);
        read_byte(1'b1, b0);
        read_byte(1'b1, b1);
        read_byte(1'b1, b2);
        read_byte(1'b0, b3);
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rd_release_after_nack: got %b expected 0", sda_oe); end
        i2c_stop();
        n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("FAIL rd_acks: got %b expected 111", {a0, a1, a2}); end
        n_cmp++; if (b0 !== 8'hCD) begin n_err++; $display("FAIL rd_byte0: got %h expected CD", b0); end
        n_cmp++; if (b1 !== 8'hAB) begin n_err++; $display("FAIL rd_byte1: got %h expected AB", b1); end
        n_cmp++; if (b2 !== 8'h34) begin n_err++; $display("FAIL rd_byte2: got %h expected 34", b2); end
        n_cmp++; if (b3 !== 8'h12) begin n_err++; $display("FAIL rd_byte3: got %h expected 12", b3); end
    endtask

    task automatic test_wrong_address();
        logic a0;
        i2c_start();
        write_byte(8'h8A, a0);
        n_cmp++; if (a0 !== 1'b0) begin n_err++; $display("FAIL na_ack: got %b expected 0", a0); end
        write_byte(8'h01, a0);
        write_byte(8'h77, a0);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL na_busy: got %b expected 1", busy); end
        i2c_stop();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL na_busy_stop: got %b expected 0", busy); end
        n_cmp++; if (config1 !== 8'h05) begin n_err++; $display("FAIL na_config1: got %h expected 05", config1); end
    endtask

    task automatic test_shadow_coherency();
        logic a0, a1, a2;
        logic [7:0] b0, b1;
        green = 16'hABCD;
        i2c_start();
        write_byte(8'h88, a0);
        write_byte(8'h09, a1);
        i2c_start();
        write_byte(8'h89, a2);
        read_byte(1'b1, b0);
        green = 16'h0000;
        read_byte(1'b0, b1);
        i2c_stop();
        n_cmp++; if (b0 !== 8'hCD) begin n_err++; $display("FAIL coh_byte0: got %h expected CD", b0); end
        n_cmp++; if (b1 !== 8'hAB) begin n_err++; $display("FAIL coh_byte1: got %h expected AB", b1); end
    endtask

    task automatic test_pointer_wrap();
        logic a0, a1, a2, a3;
        logic [7:0] b0;
        int base;
        do_reset();
        // Seed config2/config3 so the final pointer position is unambiguous
        i2c_start();
        write_byte(8'h88, a0);
        write_byte(8'h02, a0);
        write_byte(8'hA5, a0);
        write_byte(8'h5A, a0);
        i2c_stop();
        base = strobe_cnt;
        i2c_start();
        write_byte(8'h88, a0);
        write_byte(8'hFF, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        i2c_stop();
        n_cmp++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_err++; $display("FAIL wrap_acks: got %b expected 1111", {a0, a1, a2, a3}); end
        n_cmp++; if (config1 !== 8'h00) begin n_err++; $display("FAIL wrap_config1: got %h expected 00", config1); end
        n_cmp++; if (config2 !== 8'hA5) begin n_err++; $display("FAIL wrap_config2: got %h expected A5", config2); end
        n_cmp++; if (config3 !== 8'h5A) begin n_err++; $display("FAIL wrap_config3: got %h expected 5A", config3); end
        n_cmp++; if (strobe_cnt - base !== 0) begin n_err++; $display("FAIL wrap_strobe_count: got %0d expected 0", strobe_cnt - base); end
        // Read from current pointer: 0x01 holds config1 = 00
        i2c_start();
        write_byte(8'h89, a0);
        read_byte(1'b1, b0);
        n_cmp++; if (b0 !== 8'h00) begin n_err++; $display("FAIL wrap_ptr_byte0: got %h expected 00", b0); end
        read_byte(1'b0, b0);
        i2c_stop();
        n_cmp++; if (b0 !== 8'hA5) begin n_err++; $display("FAIL wrap_ptr_byte1: got %h expected A5", b0); end
    endtask

    task automatic test_reset_mid_read();
        logic a0, s;
        logic [7:0] b0;
        // Point at config3 (= 5A = 0101_1010); bit 4 from MSB is 1 -> target drives low there? no: use config1 (00)
        i2c_start();
        write_byte(8'h88, a0);
        write_byte(8'h01, a0);
        i2c_start();
        write_byte(8'h89, a0);
        xfer_bit(1'b1, s);
        xfer_bit(1'b1, s);
        xfer_bit(1'b1, s);
        sda_m = 1'b1; wait_q();
        scl   = 1'b1; wait_q();
        n_cmp++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL rst_mid_driving: got %b expected 1", sda_oe); end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rst_mid_release: got %b expected 0", sda_oe); end
        reset = 1'b0;
        wait_q();
        scl = 1'b0; wait_q();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        i2c_start();
        write_byte(8'h89, a0);
        read_byte(1'b0, b0);
        i2c_stop();
        n_cmp++; if (a0 !== 1'b1) begin n_err++; $display("FAIL rst_mid_addr_ack: got %b expected 1", a0); end
        n_cmp++; if (b0 !== 8'h7D) begin n_err++; $display("FAIL rst_mid_id: got %h expected 7D", b0); end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        strobe_cnt = 0;
        reset      = 1'b1;
        scl        = 1'b1;
        sda_m      = 1'b1;
        red        = 16'h0000;
        green      = 16'h0000;
        blue       = 16'h0000;
        test_reset();
        test_write_config();
        test_read_colour();
        test_wrong_address();
        test_shadow_coherency();
        test_pointer_wrap();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
